// File: rtl/shift_swap_pipe_pkg.sv
// Shared definitions for the shift/swap pipeline.
// Contents:
//   mode_e     - operation select codes carried on the 3-bit mode bus.
//                Codes 6 and 7 have no name and are treated as HOLD.
//   MODE_W     - width of the mode bus.
package shift_swap_pipe_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD    = 3'd0,
    MODE_SHIFT   = 3'd1,
    MODE_ROTATE  = 3'd2,
    MODE_SWAP    = 3'd3,
    MODE_REVERSE = 3'd4,
    MODE_CLEAR   = 3'd5
  } mode_e;

endpackage : shift_swap_pipe_pkg

// File: rtl/shift_swap_pipe_if.sv
// Control and observation bundle for shift_swap_pipe.
// Signals:
//   en         - operation enable; low holds all state
//   mode       - operation select (see shift_swap_pipe_pkg::mode_e)
//   din        - word entering stage 0 on SHIFT
//   stages     - all stage data words, stage k at [k*WIDTH +: WIDTH]
//   dout       - data of the last stage
//   dout_valid - valid flag of the last stage
//   fill       - number of valid stages
//   full/empty - fill == DEPTH / fill == 0
// Modports: master drives en/mode/din, slave (the pipeline) drives the rest.
interface shift_swap_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import shift_swap_pipe_pkg::*;

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic                   en;
  logic [MODE_W-1:0]      mode;
  logic [WIDTH-1:0]       din;
  logic [DEPTH*WIDTH-1:0] stages;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic [FILL_W-1:0]      fill;
  logic                   full;
  logic                   empty;

  modport master (
    output en, mode, din,
    input  stages, dout, dout_valid, fill, full, empty
  );

  modport slave (
    input  en, mode, din,
    output stages, dout, dout_valid, fill, full, empty
  );

endinterface : shift_swap_pipe_if

// File: rtl/shift_swap_pipe_stage_reg.sv
// One pipeline stage: a WIDTH-bit data word plus its valid flag.
// The next value is chosen by the parent; this block only stores it.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   load     - capture d_next/v_next on this edge
//   d_next   - next data word
//   v_next   - next valid flag
//   d, v     - stored data word and valid flag
module pipe_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_next,
  input  logic             v_next,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  // NOTE: non-blocking assignments so every stage captures its
  // neighbours' pre-edge values; blocking here would ripple data
  // through several stages in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data word is cleared as well as the valid flag,
      // because dout and stages must read zero straight after reset.
      d <= '0;
      v <= 1'b0;
    end else if (load) begin
      d <= d_next;
      v <= v_next;
    end
  end

endmodule : pipe_stage_reg

// File: rtl/shift_swap_pipe.sv
// DEPTH-stage pipeline of WIDTH-bit words with per-stage valid flags.
// Supports SHIFT (din into stage 0), ROTATE, SWAP of the end stages,
// REVERSE, CLEAR and HOLD. All operations update every stage from the
// pre-edge contents in a single cycle. Outputs are taken only from the
// stage registers, so no input reaches an output combinationally.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, overrides en and mode
//   bus  - shift_swap_pipe_if slave: en/mode/din in, stage state out
module shift_swap_pipe
  import shift_swap_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  shift_swap_pipe_if.slave   bus
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];
  mode_e            mode;

  // Unlisted codes (6, 7) fall to the default branch and hold.
  assign mode = mode_e'(bus.mode);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // Source stages for this position under each reordering op.
    localparam int PREV = (k + DEPTH - 1) % DEPTH;
    localparam int MIRR = DEPTH - 1 - k;
    localparam int XCHG = (k == 0) ? DEPTH - 1 : ((k == DEPTH - 1) ? 0 : k);

    logic [WIDTH-1:0] d_next;
    logic             v_next;

    always_comb begin
      // NOTE: defaults first so every path assigns both outputs and
      // no latch is inferred; the default is "hold this stage".
      d_next = data_q[k];
      v_next = valid_q[k];
      case (mode)
        MODE_SHIFT: begin
          if (k == 0) begin
            d_next = bus.din;
            v_next = 1'b1;
          end else begin
            d_next = data_q[PREV];
            v_next = valid_q[PREV];
          end
        end
        MODE_ROTATE: begin
          d_next = data_q[PREV];
          v_next = valid_q[PREV];
        end
        MODE_SWAP: begin
          d_next = data_q[XCHG];
          v_next = valid_q[XCHG];
        end
        MODE_REVERSE: begin
          d_next = data_q[MIRR];
          v_next = valid_q[MIRR];
        end
        MODE_CLEAR: begin
          d_next = '0;
          v_next = 1'b0;
        end
        default: ;
      endcase
    end

    pipe_stage_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (bus.en),
      .d_next (d_next),
      .v_next (v_next),
      .d      (data_q[k]),
      .v      (valid_q[k])
    );
  end : g_stage

  // Flattened stage view and valid population count, from registers only.
  logic [DEPTH*WIDTH-1:0] stages_c;
  logic [FILL_W-1:0]      fill_c;

  always_comb begin
    stages_c = '0;
    fill_c   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stages_c[k*WIDTH +: WIDTH] = data_q[k];
      fill_c = fill_c + FILL_W'(valid_q[k]);
    end
  end

  assign bus.stages     = stages_c;
  assign bus.dout       = data_q[DEPTH-1];
  assign bus.dout_valid = valid_q[DEPTH-1];
  assign bus.fill       = fill_c;
  assign bus.full       = (fill_c == FILL_W'(DEPTH));
  assign bus.empty      = (fill_c == '0);

endmodule : shift_swap_pipe

// File: tb/tb_shift_swap_pipe.sv
// Self-checking bench for shift_swap_pipe (WIDTH=8, DEPTH=4):
// a directed vector table followed by a randomized run against an
// array-based model of the operation rules.
module tb_shift_swap_pipe;
  import shift_swap_pipe_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic clk;
  logic rst;

  shift_swap_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shift_swap_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Apply one set of inputs across one rising edge, then sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [WIDTH-1:0] d);
    rst      = r;
    bus.en   = e;
    bus.mode = m;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic                   rst;
    logic                   en;
    logic [2:0]             mode;
    logic [WIDTH-1:0]       din;
    logic [DEPTH*WIDTH-1:0] exp_stages;  // {s3,s2,s1,s0}
    int                     exp_fill;
    logic                   exp_dv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] d, input logic [31:0] s,
                     input int f, input logic dv);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.din = d;
    v.exp_stages = s; v.exp_fill = f; v.exp_dv = dv;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag,
                               input logic [DEPTH*WIDTH-1:0] s,
                               input int f, input logic dv);
    check({tag, " stages"}, 32'(bus.stages), 32'(s));
    check({tag, " dout"}, 32'(bus.dout), 32'(s[(DEPTH-1)*WIDTH +: WIDTH]));
    check({tag, " dout_valid"}, 32'(bus.dout_valid), 32'(dv));
    check({tag, " fill"}, 32'(bus.fill), 32'(f));
    check({tag, " full"}, 32'(bus.full), 32'(f == DEPTH));
    check({tag, " empty"}, 32'(bus.empty), 32'(f == 0));
  endtask

  // Reference model: plain arrays updated from the operation rules.
  logic [WIDTH-1:0] md [DEPTH];
  logic             mv [DEPTH];

  task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                            input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] od [DEPTH];
    logic             ov [DEPTH];
    od = md;
    ov = mv;
    if (r) begin
      for (int k = 0; k < DEPTH; k++) begin md[k] = '0; mv[k] = 1'b0; end
    end else if (e) begin
      case (m)
        3'd1: begin  // shift: new word enters, oldest leaves
          md[0] = d; mv[0] = 1'b1;
          for (int k = 1; k < DEPTH; k++) begin md[k] = od[k-1]; mv[k] = ov[k-1]; end
        end
        3'd2: begin  // rotate: last wraps to first
          for (int k = 0; k < DEPTH; k++) begin
            md[(k + 1) % DEPTH] = od[k]; mv[(k + 1) % DEPTH] = ov[k];
          end
        end
        3'd3: begin  // swap the two ends
          md[0] = od[DEPTH-1]; mv[0] = ov[DEPTH-1];
          md[DEPTH-1] = od[0]; mv[DEPTH-1] = ov[0];
        end
        3'd4: begin  // reverse order
          for (int k = 0; k < DEPTH; k++) begin md[k] = od[DEPTH-1-k]; mv[k] = ov[DEPTH-1-k]; end
        end
        3'd5: begin
          for (int k = 0; k < DEPTH; k++) begin md[k] = '0; mv[k] = 1'b0; end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [DEPTH*WIDTH-1:0] exp_s;
    int                     exp_f;
    logic                   r, e;
    logic [2:0]             m;
    logic [WIDTH-1:0]       d;

    rst = 1'b1; bus.en = 1'b0; bus.mode = 3'd0; bus.din = '0;

    // Directed table: {rst, en, mode, din} -> {stages {s3,s2,s1,s0}, fill, dout_valid}
    add(1, 1, 3'd1, 8'h00, 32'h00000000, 0, 0);  // reset
    add(0, 1, 3'd1, 8'h11, 32'h00000011, 1, 0);
    add(0, 1, 3'd1, 8'h22, 32'h00001122, 2, 0);
    add(0, 1, 3'd1, 8'h33, 32'h00112233, 3, 0);
    add(0, 1, 3'd1, 8'h44, 32'h11223344, 4, 1);  // full, dout=0x11
    add(0, 1, 3'd3, 8'h00, 32'h44223311, 4, 1);  // swap ends
    add(0, 1, 3'd4, 8'h00, 32'h11332244, 4, 1);  // reverse
    add(0, 1, 3'd1, 8'h55, 32'h33224455, 4, 1);  // shift when full
    add(0, 0, 3'd1, 8'hFF, 32'h33224455, 4, 1);  // en low
    add(0, 0, 3'd1, 8'hFF, 32'h33224455, 4, 1);
    add(0, 0, 3'd1, 8'hFF, 32'h33224455, 4, 1);
    add(0, 1, 3'd7, 8'hFF, 32'h33224455, 4, 1);  // unused code
    add(0, 1, 3'd6, 8'hFF, 32'h33224455, 4, 1);
    add(0, 1, 3'd0, 8'hFF, 32'h33224455, 4, 1);  // hold
    add(0, 1, 3'd5, 8'hFF, 32'h00000000, 0, 0);  // clear
    add(0, 1, 3'd1, 8'hAA, 32'h000000AA, 1, 0);
    add(0, 1, 3'd2, 8'h00, 32'h0000AA00, 1, 0);  // rotate x3
    add(0, 1, 3'd2, 8'h00, 32'h00AA0000, 1, 0);
    add(0, 1, 3'd2, 8'h00, 32'hAA000000, 1, 1);
    add(0, 1, 3'd2, 8'h00, 32'h000000AA, 1, 0);  // wrap back to s0
    add(1, 0, 3'd0, 8'h00, 32'h00000000, 0, 0);
    add(0, 1, 3'd1, 8'h5A, 32'h0000005A, 1, 0);
    add(0, 1, 3'd1, 8'h6B, 32'h00005A6B, 2, 0);
    add(1, 1, 3'd1, 8'h77, 32'h00000000, 0, 0);  // reset beats shift
    add(0, 1, 3'd1, 8'h01, 32'h00000001, 1, 0);
    add(0, 1, 3'd3, 8'h00, 32'h01000000, 1, 1);  // swap moves valid too
    add(0, 1, 3'd4, 8'h00, 32'h00000001, 1, 0);
    add(1, 0, 3'd5, 8'h00, 32'h00000000, 0, 0);  // reset with en low

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].din);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_stages,
                    vecs[i].exp_fill, vecs[i].exp_dv);
    end

    // Latency: a word shifted in appears on dout after DEPTH-1 more shifts.
    step(1, 0, 3'd0, 8'h00);
    step(0, 1, 3'd1, 8'hC3);
    for (int i = 0; i < DEPTH - 2; i++) step(0, 1, 3'd1, 8'(i));
    check("latency early", 32'(bus.dout_valid), 32'd0);
    step(0, 1, 3'd1, 8'h00);
    check("latency dout", 32'(bus.dout), 32'hC3);
    check("latency valid", 32'(bus.dout_valid), 32'd1);

    // Randomized run against the model.
    step(1, 0, 3'd0, 8'h00);
    for (int k = 0; k < DEPTH; k++) begin md[k] = '0; mv[k] = 1'b0; end
    for (int n = 0; n < 500; n++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      d = 8'($urandom);
      step(r, e, m, d);
      model_step(r, e, m, d);
      exp_f = 0;
      for (int k = 0; k < DEPTH; k++) begin
        exp_s[k*WIDTH +: WIDTH] = md[k];
        if (mv[k]) exp_f++;
      end
      check_outputs($sformatf("rand%0d", n), exp_s, exp_f, mv[DEPTH-1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_swap_pipe

// File: doc/shift_swap_pipe.md
SHIFT_SWAP_PIPE -- requirements
Module: shift_swap_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each stage register; legal range 1..32.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages; legal range 2..16.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port en  input  1: operation enable; when low, all state holds regardless of mode.
REQ-006 Port mode  input  3: operation select, encoded HOLD=0, SHIFT=1, ROTATE=2, SWAP=3, REVERSE=4, CLEAR=5; codes 6..7 behave as HOLD.
REQ-007 Port din  input  WIDTH: data entering stage 0 on SHIFT.
REQ-008 Port stages  output  DEPTH*WIDTH: all stage registers flattened; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port dout  output  WIDTH: stage DEPTH-1 contents.
REQ-010 Port dout_valid  output  1: valid flag of stage DEPTH-1.
REQ-011 Port fill  output  $clog2(DEPTH+1): number of valid stages.
REQ-012 Port full  output  1: high when fill == DEPTH.
REQ-013 Port empty  output  1: high when fill == 0.

Function
REQ-014 Each stage SHALL hold a WIDTH-bit data word and a 1-bit valid flag; all updates for one cycle SHALL use pre-edge values only (non-blocking semantics, no intra-cycle ripple).
REQ-015 SHIFT: stage0 <= din with valid 1; stage k <= stage k-1 (data and valid) for k = 1..DEPTH-1; the old stage DEPTH-1 is discarded.
REQ-016 ROTATE: stage0 <= stage DEPTH-1; stage k <= stage k-1; valid flags rotate with data; fill unchanged.
REQ-017 SWAP: stage0 and stage DEPTH-1 SHALL exchange data and valid in one cycle; the middle stages hold; fill unchanged.
REQ-018 REVERSE: stage k <= stage DEPTH-1-k for all k, with data and valid; fill unchanged.
REQ-019 CLEAR: all data and valid flags SHALL go to 0 in one cycle; fill <= 0.
REQ-020 HOLD, or en low: no state change.
REQ-021 fill SHALL equal the population count of the valid flags after every edge.
REQ-022 SHIFT when full: fill stays DEPTH, the oldest word is dropped, and there is no error indication.
REQ-023 All outputs SHALL be registered or derived combinationally from registered state only; there is no combinational path from din, mode or en to any output.
REQ-024 Latency: a word shifted in at edge N SHALL appear on dout after edge N+DEPTH-1, given consecutive SHIFT cycles.

Reset
REQ-025 rst high at a rising edge SHALL clear all data and valid flags, so that fill=0, empty=1, full=0, dout=0 and dout_valid=0; rst takes priority over en and mode.
REQ-026 Reset asserted mid-sequence SHALL discard all contents in the same edge; operation resumes on the first edge after rst deasserts.

Structure
REQ-027 Mode encodings (HOLD..CLEAR) SHALL live in the shared package as named constants; WIDTH and DEPTH remain module parameters.
REQ-028 One sub-module, pipe_stage_reg (WIDTH-bit data plus valid, with rst, load enable and next-value inputs), SHALL be instantiated DEPTH times by a generate loop.
REQ-029 The next-value mux per stage SHALL reside in shift_swap_pipe, not in pipe_stage_reg.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset, then SHIFT din=0x11,0x22,0x33,0x44 on four edges -> stages={s0=0x44,s1=0x33,s2=0x22,s3=0x11}, fill=4, full=1, dout=0x11 after the 4th edge.
REQ-031 From the REQ-030 state: one SWAP -> s0=0x11, s3=0x44; then one REVERSE -> {0x44,0x22,0x33,0x11}; fill stays 4.
REQ-032 Reset, SHIFT 0xAA once, then ROTATE three times -> dout=0xAA, dout_valid=1, fill=1.
REQ-033 Full pipe, then SHIFT 0x55 -> s0=0x55, the old 0x11 is lost, fill=4; then CLEAR -> all zero, empty=1.
REQ-034 Mode=SHIFT with en=0 for 3 cycles -> no change; mode=7 with en=1 -> no change.
REQ-035 Two SHIFTs, then rst=1 together with mode=SHIFT -> all zero, fill=0; next SHIFT 0x01 -> fill=1, s0=0x01.
